fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 115 +++++++++++
 tb/tb_fifo_stream_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Credit-based FIFO-to-stream adapter with a 4-entry circular buffer absorbing FIFO read latency.
// Define FSR_LINE_LAST_EN to enable the column counter that drives m_last every LINE_WIDTH beats.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned LINE_WIDTH = 640
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [2:0]            buf_level
);
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned CRED_W = CNT_W + 1;

    if (DATA_WIDTH == 0 || DATA_WIDTH > 256 || (RD_LAT != 1 && RD_LAT != 2) ||
        LINE_WIDTH < 2 || LINE_WIDTH > 4096) begin : g_param_check
        $error("fifo_stream_reader: parameter out of range");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [CNT_W-1:0]      infl_q, infl_d;
    logic [RD_LAT-1:0]     lat_q, lat_d;
    logic [CRED_W-1:0]     credit_used;
    logic                  capture_c;
    logic                  pop_c;

    // Credits cover both buffered words and reads still travelling through the FIFO pipeline.
    assign credit_used = {1'b0, occ_q} + {1'b0, infl_q};
    assign fifo_rd_en  = rst_n & ~fifo_empty & (credit_used < CRED_W'(DEPTH));
    assign capture_c   = lat_q[RD_LAT-1];

    assign m_valid   = (occ_q != '0);
    assign pop_c     = m_valid & m_ready;
    assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
    assign buf_level = occ_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        infl_d   = infl_q;
        lat_d    = RD_LAT'({lat_q, fifo_rd_en});
        if (capture_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        occ_d  = occ_q + CNT_W'(capture_c) - CNT_W'(pop_c);
        infl_d = infl_q + CNT_W'(fifo_rd_en) - CNT_W'(capture_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            infl_q   <= '0;
            lat_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
            lat_q    <= lat_d;
        end
    end

    // Data storage needs no reset: m_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (capture_c) begin
            mem_q[wr_ptr_q] <= fifo_rd_data;
        end
    end

`ifdef FSR_LINE_LAST_EN
    localparam int unsigned COL_W = 12;

    logic [COL_W-1:0] col_q, col_d;
    logic             eol_c;

    assign eol_c  = (col_q == COL_W'(LINE_WIDTH - 1));
    assign m_last = eol_c & m_valid;

    always_comb begin
        col_d = col_q;
        if (pop_c) begin
            col_d = eol_c ? '0 : col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: one reader with RD_LAT=1 and one with RD_LAT=2 fed identical FIFO contents.
`timescale 1ns/1ps
module tb_fifo_stream_reader;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 4;
    localparam int unsigned MEM_N = 2048;
`ifdef FSR_LINE_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, m_ready, force_empty;
    logic          fe_a, fe_b, rd_en_a, rd_en_b, mv_a, mv_b, ml_a, ml_b;
    logic [DW-1:0] rd_data_a, rd_data_b, stage_b, md_a, md_b;
    logic [2:0]    lvl_a, lvl_b;

    logic [DW-1:0] src [MEM_N];
    int            wr_idx, base_idx, rd_a, rd_b, cyc;
    int            exp_idx [2];
    int            beat [2];
    int            rden_cnt [2];
    int            xcyc [2][MEM_N];
    int            n_checks, n_fail;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_stream_reader #(.DATA_WIDTH(DW), .RD_LAT(1), .LINE_WIDTH(LW)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe_a), .fifo_rd_en(rd_en_a),
        .fifo_rd_data(rd_data_a), .m_valid(mv_a), .m_ready(m_ready),
        .m_data(md_a), .m_last(ml_a), .buf_level(lvl_a));

    fifo_stream_reader #(.DATA_WIDTH(DW), .RD_LAT(2), .LINE_WIDTH(LW)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fe_b), .fifo_rd_en(rd_en_b),
        .fifo_rd_data(rd_data_b), .m_valid(mv_b), .m_ready(m_ready),
        .m_data(md_b), .m_last(ml_b), .buf_level(lvl_b));

    // FIFO models share the written word list; each keeps its own read index and latency.
    assign fe_a = force_empty | (rd_a == wr_idx);
    assign fe_b = force_empty | (rd_b == wr_idx);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a <= base_idx;
        end else if (rd_en_a) begin
            rd_data_a <= src[rd_a];
            rd_a      <= rd_a + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_b <= base_idx;
        end else begin
            rd_data_b <= stage_b;
            if (rd_en_b) begin
                stage_b <= src[rd_b];
                rd_b    <= rd_b + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_last(input int b);
        return LAST_EN && ((b % int'(LW)) == int'(LW) - 1);
    endfunction

    task automatic mon(input int k, input logic rde, fe, mv, ml,
                       input logic [DW-1:0] md, input logic [2:0] lvl);
        check("level_max", 64'(lvl <= 3'd4), 64'(1));
        check("valid_vs_level", 64'(mv), 64'(lvl != 3'd0));
        if (rde) begin
            check("rd_en_while_empty", 64'(fe), 64'(0));
            rden_cnt[k]++;
        end
        if (mv && m_ready) begin
            check("stream_data", 64'(md), 64'(src[exp_idx[k]]));
            check("m_last", 64'(ml), 64'(exp_last(beat[k])));
            xcyc[k][exp_idx[k]] = cyc;
            exp_idx[k]++;
            beat[k]++;
        end
    endtask

    // Scoreboard sampled on the falling edge; reset restarts expectations at the new FIFO base.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                exp_idx[k] = base_idx;
                beat[k]    = 0;
            end
        end else begin
            mon(0, rd_en_a, fe_a, mv_a, ml_a, md_a, lvl_a);
            mon(1, rd_en_b, fe_b, mv_b, ml_b, md_b, lvl_b);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        src[wr_idx] = v;
        wr_idx++;
    endtask

    initial begin
        int fr [2];
        int fv [2];
        int snap [2];
        int start;
        bit hit;

        rst_n = 1'b1; m_ready = 1'b0; force_empty = 1'b0;
        wr_idx = 0; base_idx = 0;
        #1 rst_n = 1'b0;

        // Reset with a preloaded FIFO: nothing may move.
        for (int i = 1; i <= 8; i++) push(DW'(i));
        step(3);
        check("rst_rd_en_l1", 64'(rd_en_a), 64'(0));
        check("rst_rd_en_l2", 64'(rd_en_b), 64'(0));
        check("rst_valid_l1", 64'(mv_a), 64'(0));
        check("rst_valid_l2", 64'(mv_b), 64'(0));
        check("rst_level_l1", 64'(lvl_a), 64'(0));
        check("rst_level_l2", 64'(lvl_b), 64'(0));
        check("rst_data_l1", 64'(md_a), 64'(0));
        check("rst_data_l2", 64'(md_b), 64'(0));
        check("rst_last_l1", 64'(ml_a), 64'(0));
        check("rst_last_l2", 64'(ml_b), 64'(0));

        // Preloaded 1..8 with m_ready high: latency and back-to-back streaming.
        m_ready = 1'b1;
        fr = '{-1, -1};
        fv = '{-1, -1};
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (fr[0] < 0 && rd_en_a) fr[0] = cyc;
            if (fv[0] < 0 && mv_a)    fv[0] = cyc;
            if (fr[1] < 0 && rd_en_b) fr[1] = cyc;
            if (fv[1] < 0 && mv_b)    fv[1] = cyc;
            @(negedge clk);
        end
        check("first_valid_lat_l1", 64'(fv[0] - fr[0]), 64'(2));
        check("first_valid_lat_l2", 64'(fv[1] - fr[1]), 64'(3));
        for (int k = 0; k < 2; k++) begin
            check("preload_count", 64'(exp_idx[k]), 64'(8));
            check("preload_back_to_back", 64'(xcyc[k][7] - xcyc[k][0]), 64'(7));
        end

        // Stalled downstream with 10 words queued: exactly 4 credits used.
        step(1);
        m_ready = 1'b0;
        snap[0] = rden_cnt[0];
        snap[1] = rden_cnt[1];
        start = wr_idx;
        for (int i = 0; i < 10; i++) push(DW'(32'h100 + i));
        step(20);
        check("stall_rd_pulses_l1", 64'(rden_cnt[0] - snap[0]), 64'(4));
        check("stall_rd_pulses_l2", 64'(rden_cnt[1] - snap[1]), 64'(4));
        check("stall_level_l1", 64'(lvl_a), 64'(4));
        check("stall_level_l2", 64'(lvl_b), 64'(4));
        check("stall_head_l1", 64'(md_a), 64'(32'h100));
        check("stall_head_l2", 64'(md_b), 64'(32'h100));
        step(3);
        check("stall_hold_l1", 64'(md_a), 64'(32'h100));
        check("stall_hold_l2", 64'(md_b), 64'(32'h100));
        check("stall_valid_l2", 64'(mv_b), 64'(1));
        m_ready = 1'b1;
        step(20);
        for (int k = 0; k < 2; k++) begin
            check("stall_drain_count", 64'(exp_idx[k]), 64'(wr_idx));
            check("stall_no_gap", 64'(xcyc[k][start + 9] - xcyc[k][start]), 64'(9));
        end

        // FIFO empty flag toggling every cycle.
        snap[0] = rden_cnt[0];
        snap[1] = rden_cnt[1];
        for (int i = 0; i < 8; i++) push(DW'(32'h200 + i));
        for (int n = 0; n < 40; n++) begin
            force_empty = ~force_empty;
            step(1);
        end
        force_empty = 1'b0;
        step(10);
        for (int k = 0; k < 2; k++) begin
            check("toggle_count", 64'(exp_idx[k]), 64'(wr_idx));
            check("toggle_rd_pulses", 64'(rden_cnt[k] - snap[k]), 64'(8));
        end

        // 1000 words under random backpressure.
        for (int i = 0; i < 1000; i++) push(DW'(32'h1000 + i));
        for (int n = 0; n < 8000 && (exp_idx[0] != wr_idx || exp_idx[1] != wr_idx); n++) begin
            m_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        m_ready = 1'b1;
        step(2);
        for (int k = 0; k < 2; k++) begin
            check("random_count", 64'(exp_idx[k]), 64'(wr_idx));
        end

        // Reset mid-operation with words buffered and in flight.
        m_ready = 1'b0;
        step(1);
        for (int i = 0; i < 10; i++) push(DW'(32'h300 + i));
        hit = 1'b0;
        for (int n = 0; n < 30 && !hit; n++) begin
            @(negedge clk);
            if (lvl_b == 3'd3) hit = 1'b1;
        end
        check("reach_level3", 64'(hit), 64'(1));
        base_idx = wr_idx;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_l1", 64'(mv_a), 64'(0));
        check("midrst_valid_l2", 64'(mv_b), 64'(0));
        check("midrst_level_l1", 64'(lvl_a), 64'(0));
        check("midrst_level_l2", 64'(lvl_b), 64'(0));
        for (int i = 0; i < 6; i++) push(DW'(32'h400 + i));
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        #1;
        check("resume_rd_en_l1", 64'(rd_en_a), 64'(1));
        check("resume_rd_en_l2", 64'(rd_en_b), 64'(1));
        step(15);
        for (int k = 0; k < 2; k++) begin
            check("restart_count", 64'(exp_idx[k] - base_idx), 64'(6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
